// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Framed byte-stream loader for the byte-addressed instruction
//            memory; holds the CPU in reset until a clean load completes.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  // Usable bytes above the base; 17 bits so a full 64 KiB space still fits.
  localparam logic [16:0]       c_cap  = 17'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [7:0]        r_csum;
  logic [ADDR_W-1:0] r_ptr;

  logic        w_xfer;
  logic [15:0] w_len;
  logic        w_last;

  assign w_xfer = in_valid & in_ready;
  assign w_len  = {r_len[15:8], in_byte};
  assign w_last = (r_cnt == (r_len - 16'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_len     <= 16'd0;
      r_cnt     <= 16'd0;
      r_csum    <= 8'd0;
      r_ptr     <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state  <= LEN_HI;
            r_cnt    <= 16'd0;
            r_csum   <= 8'd0;
            r_ptr    <= c_base;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
          end
        end
        LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= in_byte;
            r_state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= in_byte;
            // Capacity is checked ahead of alignment.
            if ({1'b0, w_len} > c_cap) begin
              r_state  <= ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'b01;
            end else if (w_len[1:0] != 2'b00) begin
              r_state  <= ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'b10;
            end else if (w_len == 16'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_csum    <= r_csum ^ in_byte;
            r_cnt     <= r_cnt + 16'd1;
            r_ptr     <= r_ptr + 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= r_ptr;
            mem_wdata <= in_byte;
            if (w_last) begin
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_xfer) begin
            in_ready <= 1'b0;
            if (in_byte == r_csum) begin
              r_state  <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state  <= ERROR;
              error    <= 1'b1;
              err_code <= 2'b11;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  int checks = 0;
  int fails  = 0;

  logic [ADDR_W-1:0] wa [0:63];
  logic [7:0]        wd [0:63];
  int                wn = 0;
  int                wbase;

  logic [7:0] pay [0:7] = '{8'h02, 8'h32, 8'h40, 8'h22, 8'h02, 8'h11, 8'h48, 8'h22};
  int         gp  [0:7] = '{0, 2, 1, 0, 3, 0, 1, 2};
  // XOR of the eight payload bytes above.
  localparam logic [7:0] c_good_sum = 8'h2B;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_byte(in_byte), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1 && wn < 64) begin
      wa[wn] = mem_addr;
      wd[wn] = mem_wdata;
      wn++;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      fails++;
      $display("FAIL send_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_nominal(input logic [7:0] sum, input bit gaps);
    send(8'h00, 0);
    send(8'h08, gaps ? 1 : 0);
    for (int i = 0; i < 8; i++) send(pay[i], gaps ? (i == 0 ? 4 : gp[i]) : 0);
    send(sum, gaps ? 2 : 0);
    idle(3);
  endtask

  task automatic check_writes8(input string tag);
    checks++;
    if (wn - wbase !== 8) begin
      fails++;
      $display("FAIL %s_count: got %0d writes, required 8", tag, wn - wbase);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wa[wbase+i] !== ADDR_W'(i) || wd[wbase+i] !== pay[i]) begin
          fails++;
          $display("FAIL %s_write%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                   tag, i, wa[wbase+i], wd[wbase+i], i, pay[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, done, error, err_code, cpu_hold} !==
        {1'b0, 1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%0d wd=%h done=%b err=%b code=%b hold=%b, required 0 0 0 00 0 0 00 1",
               in_ready, mem_we, mem_addr, mem_wdata, done, error, err_code, cpu_hold);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    wbase = wn;
    pulse_start();
    send_nominal(c_good_sum, 1'b0);
    check_writes8("nominal");
    checks++;
    if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
      fails++;
      $display("FAIL nominal_status: done/err/hold/rdy=%b, required 1000", {done, error, cpu_hold, in_ready});
    end
  endtask

  task automatic test_checksum_error();
    wbase = wn;
    pulse_start();
    send_nominal(c_good_sum ^ 8'h01, 1'b0);
    check_writes8("cksum");
    checks++;
    if ({done, error, err_code, cpu_hold} !== 5'b01111) begin
      fails++;
      $display("FAIL cksum_status: done/err/code/hold=%b, required 01111", {done, error, err_code, cpu_hold});
    end
  endtask

  task automatic test_length();
    wbase = wn;
    pulse_start();
    send(8'h04, 0); send(8'h01, 0); idle(2);
    checks++;
    if ({error, err_code, in_ready, done} !== 5'b10100 || wn != wbase) begin
      fails++;
      $display("FAIL len_capacity: err/code/rdy/done=%b writes=%0d, required 10100 writes=0",
               {error, err_code, in_ready, done}, wn - wbase);
    end
    pulse_start();
    send(8'h00, 0); send(8'h06, 0); idle(2);
    checks++;
    if ({error, err_code, cpu_hold} !== 4'b1101) begin
      fails++;
      $display("FAIL len_align: err/code/hold=%b, required 1101", {error, err_code, cpu_hold});
    end
    wbase = wn;
    pulse_start();
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); idle(2);
    checks++;
    if ({done, error, err_code, cpu_hold} !== 5'b10000 || wn != wbase) begin
      fails++;
      $display("FAIL len_zero: done/err/code/hold=%b writes=%0d, required 10000 writes=0",
               {done, error, err_code, cpu_hold}, wn - wbase);
    end
  endtask

  task automatic test_backpressure();
    wbase = wn;
    pulse_start();
    send_nominal(c_good_sum, 1'b1);
    check_writes8("gaps");
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      fails++;
      $display("FAIL gaps_status: done/err/hold=%b, required 100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_reset_mid_load();
    wbase = wn;
    pulse_start();
    send(8'h00, 0); send(8'h08, 0);
    for (int i = 0; i < 3; i++) send(pay[i], 0);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, done, error, err_code, cpu_hold} !==
        {1'b0, 1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
      fails++;
      $display("FAIL midreset_values: rdy=%b we=%b addr=%0d wd=%h done=%b err=%b code=%b hold=%b, required 0 0 0 00 0 0 00 1",
               in_ready, mem_we, mem_addr, mem_wdata, done, error, err_code, cpu_hold);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (wn - wbase < 2 || wn - wbase > 3) begin
      fails++;
      $display("FAIL midreset_writes: got %0d writes, required 2 or 3", wn - wbase);
    end
    wbase = wn;
    pulse_start();
    send_nominal(c_good_sum, 1'b0);
    check_writes8("afterreset");
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      fails++;
      $display("FAIL afterreset_status: done/err/hold=%b, required 100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_reload();
    wbase = wn;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({cpu_hold, done, in_ready} !== 3'b101) begin
      fails++;
      $display("FAIL reload_hold: hold/done/rdy=%b, required 101", {cpu_hold, done, in_ready});
    end
    send(8'h00, 0); send(8'h04, 0);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    send(8'h22, 0);  // DE^AD^BE^EF
    idle(3);
    checks++;
    if (wn - wbase !== 4 || wa[wbase] !== 10'd0 || wd[wbase] !== 8'hDE ||
        wa[wbase+3] !== 10'd3 || wd[wbase+3] !== 8'hEF) begin
      fails++;
      $display("FAIL reload_writes: count=%0d first=%0d:%h last=%0d:%h, required 4 0:de 3:ef",
               wn - wbase, wa[wbase], wd[wbase], wa[wbase+3], wd[wbase+3]);
    end
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      fails++;
      $display("FAIL reload_status: done/err/hold=%b, required 100", {done, error, cpu_hold});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_checksum_error();
    test_length();
    test_backpressure();
    test_reset_mid_load();
    test_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
